// File: rtl/cache_ctrl_pkg.sv
// Shared geometry, address field layout and FSM encoding for the cache miss controller.
package cache_ctrl_pkg;

    localparam int ADDR_BITS        = 32;
    localparam int WORD_BITS        = 32;
    localparam int TAG_BITS         = 22;
    localparam int LINE_WORDS       = 4;
    localparam int LINE_WORDS_WIDTH = 2;
    localparam int WORD_BYTES_WIDTH = 2;
    localparam int INDEX_BITS       = ADDR_BITS - TAG_BITS - LINE_WORDS_WIDTH - WORD_BYTES_WIDTH;

    // Bit positions of each address field, LSB first: byte, word, index, tag.
    localparam int WORD_LSB  = WORD_BYTES_WIDTH;
    localparam int INDEX_LSB = WORD_LSB + LINE_WORDS_WIDTH;
    localparam int TAG_LSB   = INDEX_LSB + INDEX_BITS;

    localparam logic [LINE_WORDS_WIDTH-1:0] LAST_WORD = LINE_WORDS_WIDTH'(LINE_WORDS - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WB   = 2'd1,
        FILL = 2'd2,
        DONE = 2'd3
    } state_t;

    // Rebuild a word-aligned address from its tag, index and word-in-line fields.
    function automatic logic [ADDR_BITS-1:0] line_word_addr(
        input logic [TAG_BITS-1:0]         tag,
        input logic [INDEX_BITS-1:0]       index,
        input logic [LINE_WORDS_WIDTH-1:0] word
    );
        return {tag, index, word, {WORD_BYTES_WIDTH{1'b0}}};
    endfunction

endpackage

// File: rtl/cache_ctrl.sv
// Write-back, write-allocate miss controller for a single cache_line store.
// Hits are served combinationally; misses write back a dirty victim then refill.
module cache_ctrl
    import cache_ctrl_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,

    input  logic                 cpu_req,
    input  logic                 cpu_we,
    input  logic [ADDR_BITS-1:0] cpu_addr,
    input  logic [WORD_BITS-1:0] cpu_din,
    output logic [WORD_BITS-1:0] cpu_dout,
    output logic                 cpu_stall,
    input  logic                 inv_req,

    output logic [ADDR_BITS-1:0] ln_addr,
    output logic                 ln_load,
    output logic                 ln_edit,
    output logic                 ln_invalid,
    output logic [WORD_BITS-1:0] ln_din,
    input  logic                 ln_hit,
    input  logic                 ln_valid,
    input  logic                 ln_dirty,
    input  logic [WORD_BITS-1:0] ln_dout,
    input  logic [TAG_BITS-1:0]  ln_tag,

    output logic                 mem_cs,
    output logic                 mem_we,
    output logic [ADDR_BITS-1:0] mem_addr,
    output logic [WORD_BITS-1:0] mem_dout,
    input  logic [WORD_BITS-1:0] mem_din,
    input  logic                 mem_ack
);

    state_t                      state_q, state_d;
    logic [LINE_WORDS_WIDTH-1:0] word_cnt_q, word_cnt_d;
    logic [TAG_BITS-1:0]         victim_tag_q, victim_tag_d;

    logic [TAG_BITS-1:0]         cpu_tag;
    logic [INDEX_BITS-1:0]       cpu_index;
    logic                        unused_addr_bits;

    assign cpu_tag          = cpu_addr[ADDR_BITS-1:TAG_LSB];
    assign cpu_index        = cpu_addr[TAG_LSB-1:INDEX_LSB];
    // Byte offset and the CPU's own word select are not needed by the controller itself.
    assign unused_addr_bits = ^cpu_addr[INDEX_LSB-1:0];

    // State, refill word counter and victim tag; async reset abandons any memory transaction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            word_cnt_q   <= '0;
            victim_tag_q <= '0;
        end else begin
            state_q      <= state_d;
            word_cnt_q   <= word_cnt_d;
            victim_tag_q <= victim_tag_d;
        end
    end

    // Next-state and all outputs; every output defaults to its idle value.
    always_comb begin
        state_d      = state_q;
        word_cnt_d   = word_cnt_q;
        victim_tag_d = victim_tag_q;

        cpu_dout     = '0;
        cpu_stall    = 1'b0;
        ln_addr      = cpu_addr;
        ln_load      = 1'b0;
        ln_edit      = 1'b0;
        ln_invalid   = 1'b0;
        ln_din       = '0;
        mem_cs       = 1'b0;
        mem_we       = 1'b0;
        mem_addr     = '0;
        mem_dout     = '0;

        unique case (state_q)
            IDLE: begin
                if (cpu_req) begin
                    if (ln_hit) begin
                        if (cpu_we) begin
                            ln_edit = 1'b1;
                            ln_din  = cpu_din;
                        end else begin
                            cpu_dout = ln_dout;
                        end
                    end else begin
                        cpu_stall  = 1'b1;
                        word_cnt_d = '0;
                        if (ln_valid && ln_dirty) begin
                            victim_tag_d = ln_tag;
                            state_d      = WB;
                        end else begin
                            state_d = FILL;
                        end
                    end
                end else if (inv_req) begin
                    // Dirty contents are dropped on purpose: no write-back on invalidate.
                    ln_invalid = 1'b1;
                end
            end

            WB: begin
                cpu_stall = 1'b1;
                mem_cs    = 1'b1;
                mem_we    = 1'b1;
                mem_addr  = line_word_addr(victim_tag_q, cpu_index, word_cnt_q);
                ln_addr   = mem_addr;
                mem_dout  = ln_dout;
                if (mem_ack) begin
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        word_cnt_d = '0;
                        state_d    = FILL;
                    end
                end
            end

            FILL: begin
                cpu_stall = 1'b1;
                mem_cs    = 1'b1;
                mem_addr  = line_word_addr(cpu_tag, cpu_index, word_cnt_q);
                ln_addr   = mem_addr;
                // ln_hit goes high after the first load and is deliberately not consulted here.
                if (mem_ack) begin
                    ln_load    = 1'b1;
                    ln_din     = mem_din;
                    word_cnt_d = word_cnt_q + 1'b1;
                    if (word_cnt_q == LAST_WORD) begin
                        state_d = DONE;
                    end
                end
            end

            DONE: begin
                // One settling cycle; IDLE then replays the request as a hit.
                cpu_stall = 1'b1;
                state_d   = IDLE;
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_cache_ctrl.sv
// Directed bench for cache_ctrl with a behavioural line store and a memory with programmable ack delay.
module tb_cache_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        cpu_req = 1'b0;
    logic        cpu_we = 1'b0;
    logic [31:0] cpu_addr = '0;
    logic [31:0] cpu_din = '0;
    logic [31:0] cpu_dout;
    logic        cpu_stall;
    logic        inv_req = 1'b0;
    logic [31:0] ln_addr;
    logic        ln_load, ln_edit, ln_invalid;
    logic [31:0] ln_din;
    logic        ln_hit, ln_valid, ln_dirty;
    logic [31:0] ln_dout;
    logic [21:0] ln_tag;
    logic        mem_cs, mem_we;
    logic [31:0] mem_addr, mem_dout, mem_din;
    logic        mem_ack;

    int n_vec = 0;
    int n_err = 0;

    cache_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_req    (cpu_req),
        .cpu_we     (cpu_we),
        .cpu_addr   (cpu_addr),
        .cpu_din    (cpu_din),
        .cpu_dout   (cpu_dout),
        .cpu_stall  (cpu_stall),
        .inv_req    (inv_req),
        .ln_addr    (ln_addr),
        .ln_load    (ln_load),
        .ln_edit    (ln_edit),
        .ln_invalid (ln_invalid),
        .ln_din     (ln_din),
        .ln_hit     (ln_hit),
        .ln_valid   (ln_valid),
        .ln_dirty   (ln_dirty),
        .ln_dout    (ln_dout),
        .ln_tag     (ln_tag),
        .mem_cs     (mem_cs),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_dout   (mem_dout),
        .mem_din    (mem_din),
        .mem_ack    (mem_ack)
    );

    always #5 clk = ~clk;

    // Single-line store model; not touched by rst so a partial refill survives a reset.
    logic        lm_valid = 1'b0;
    logic        lm_dirty = 1'b0;
    logic [21:0] lm_tag   = '0;
    logic [31:0] lm_data [4];

    assign ln_hit   = lm_valid && (lm_tag == ln_addr[31:10]);
    assign ln_valid = lm_valid;
    assign ln_dirty = lm_dirty;
    assign ln_tag   = lm_tag;
    assign ln_dout  = lm_data[ln_addr[3:2]];

    always @(posedge clk) begin
        if (ln_load) begin
            lm_data[ln_addr[3:2]] <= ln_din;
            lm_tag                <= ln_addr[31:10];
            lm_valid              <= 1'b1;
            lm_dirty              <= 1'b0;
        end else if (ln_edit) begin
            lm_data[ln_addr[3:2]] <= ln_din;
            lm_dirty              <= 1'b1;
        end else if (ln_invalid) begin
            lm_valid <= 1'b0;
            lm_dirty <= 1'b0;
        end
    end

    // Memory: ack after ack_delay wait cycles; read data encodes address upper bits and word.
    int unsigned ack_delay = 0;
    logic [3:0]  wait_cnt;

    assign mem_ack = mem_cs && (wait_cnt == ack_delay[3:0]);
    assign mem_din = {mem_addr[31:16], 8'h00, 8'hA0 + {6'd0, mem_addr[3:2]}};

    always @(posedge clk or posedge rst) begin
        if (rst)                   wait_cnt <= '0;
        else if (mem_cs && !mem_ack) wait_cnt <= wait_cnt + 4'd1;
        else                       wait_cnt <= '0;
    end

    // Transaction log and protocol monitors.
    logic [31:0] wr_addr [16];
    logic [31:0] wr_data [16];
    logic [31:0] rd_addr [16];
    int          n_wr = 0, n_rd = 0, n_edit = 0, n_inv = 0, n_clash = 0, hold_err = 0;
    logic        prev_cs = 1'b0, prev_ack = 1'b0;
    logic [31:0] prev_addr = '0;

    always @(posedge clk) begin
        if (!rst && mem_cs && mem_ack) begin
            if (mem_we) begin
                if (n_wr < 16) begin
                    wr_addr[n_wr] <= mem_addr;
                    wr_data[n_wr] <= mem_dout;
                end
                n_wr <= n_wr + 1;
            end else begin
                if (n_rd < 16) rd_addr[n_rd] <= mem_addr;
                n_rd <= n_rd + 1;
            end
        end
        if (ln_edit) n_edit <= n_edit + 1;
        if (ln_invalid) n_inv <= n_inv + 1;
        if (ln_edit && ln_load) n_clash <= n_clash + 1;
        if (mem_cs && prev_cs && !prev_ack && mem_addr != prev_addr) hold_err <= hold_err + 1;
        prev_cs   <= mem_cs;
        prev_ack  <= mem_ack;
        prev_addr <= mem_addr;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One CPU access held until the stall drops; returns stalled-cycle count and load data.
    task automatic access(input logic we, input logic [31:0] addr, input logic [31:0] din,
                          output int stalls, output logic [31:0] dout);
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = we;
        cpu_addr = addr;
        cpu_din  = din;
        stalls   = 0;
        @(negedge clk);
        while (cpu_stall && stalls < 200) begin
            stalls++;
            @(negedge clk);
        end
        if (cpu_stall) check("access_timeout", 32'd1, 32'd0);
        dout = cpu_dout;
        @(posedge clk); #1;
        cpu_req = 1'b0;
        cpu_we  = 1'b0;
    endtask

    int          stalls;
    logic [31:0] dout;
    int          wr0, rd0, ed0;

    initial begin
        // Reset state with no request.
        #2;
        check("rst_strobes", {28'd0, ln_load, ln_edit, ln_invalid, cpu_stall}, 32'd0);
        check("rst_mem_ctl", {30'd0, mem_cs, mem_we}, 32'd0);
        check("rst_mem_addr", mem_addr, 32'd0);
        check("rst_mem_dout", mem_dout, 32'd0);
        check("rst_ln_din", ln_din, 32'd0);
        check("rst_cpu_dout", cpu_dout, 32'd0);
        @(negedge clk); rst = 1'b0;

        // Clean read miss on an invalid line.
        access(1'b0, 32'h0000_0104, '0, stalls, dout);
        check("clean_stalls", stalls, 32'd6);
        check("clean_dout", dout, 32'h0000_00A1);
        check("clean_n_rd", n_rd, 32'd4);
        check("clean_n_wr", n_wr, 32'd0);
        for (int i = 0; i < 4; i++) check("clean_rd_addr", rd_addr[i], 32'h100 + 32'(4 * i));

        // Store hit, then load it back.
        ed0 = n_edit;
        access(1'b1, 32'h0000_0104, 32'hDEAD_BEEF, stalls, dout);
        check("store_stalls", stalls, 32'd0);
        check("store_edits", n_edit - ed0, 32'd1);
        access(1'b0, 32'h0000_0104, '0, stalls, dout);
        check("reload_stalls", stalls, 32'd0);
        check("reload_dout", dout, 32'hDEAD_BEEF);

        // Dirty miss: write back victim then refill from the new tag.
        rd0 = n_rd;
        access(1'b0, 32'h0040_0104, '0, stalls, dout);
        check("dirty_stalls", stalls, 32'd10);
        check("dirty_n_wr", n_wr, 32'd4);
        for (int i = 0; i < 4; i++) check("dirty_wr_addr", wr_addr[i], 32'h100 + 32'(4 * i));
        check("dirty_wr_d0", wr_data[0], 32'h0000_00A0);
        check("dirty_wr_d1", wr_data[1], 32'hDEAD_BEEF);
        check("dirty_wr_d3", wr_data[3], 32'h0000_00A3);
        check("dirty_n_rd", n_rd - rd0, 32'd4);
        check("dirty_rd_a0", rd_addr[rd0], 32'h0040_0100);
        check("dirty_rd_a3", rd_addr[rd0 + 3], 32'h0040_010C);
        check("dirty_dout", dout, 32'h0040_00A1);

        // Slow memory on a clean miss.
        ack_delay = 3;
        wr0 = n_wr;
        access(1'b0, 32'h0080_0104, '0, stalls, dout);
        check("slow_stalls", stalls, 32'd18);
        check("slow_hold", hold_err, 32'd0);
        check("slow_no_wb", n_wr - wr0, 32'd0);
        check("slow_dout", dout, 32'h0080_00A1);

        // Reset while waiting on the second fill word.
        ack_delay = 2;
        @(posedge clk); #1;
        cpu_req  = 1'b1;
        cpu_we   = 1'b0;
        cpu_addr = 32'h00C0_0104;
        repeat (5) @(negedge clk);
        check("mid_fill_addr", mem_addr, 32'h00C0_0104);
        rst = 1'b1;
        #1;
        check("rst_async_cs", {31'd0, mem_cs}, 32'd0);
        check("rst_async_stall", {31'd0, cpu_stall}, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(negedge clk);
        check("post_rst_stall", {31'd0, cpu_stall}, 32'd0);
        check("post_rst_stale", cpu_dout, 32'h0080_00A1);
        @(posedge clk); #1;
        cpu_req = 1'b0;

        // Invalidate a dirty line: no traffic, next read misses cleanly.
        ack_delay = 0;
        access(1'b1, 32'h00C0_0104, 32'h1234_5678, stalls, dout);
        check("inv_store_stalls", stalls, 32'd0);
        wr0 = n_wr;
        rd0 = n_rd;
        ed0 = n_inv;
        @(posedge clk); #1;
        cpu_addr = 32'h00C0_0104;
        inv_req  = 1'b1;
        @(negedge clk);
        check("inv_strobe", {31'd0, ln_invalid}, 32'd1);
        check("inv_no_cs", {31'd0, mem_cs}, 32'd0);
        @(posedge clk); #1;
        inv_req = 1'b0;
        @(negedge clk);
        check("inv_pulses", n_inv - ed0, 32'd1);
        check("inv_no_traffic", (n_wr - wr0) + (n_rd - rd0), 32'd0);
        access(1'b0, 32'h00C0_0104, '0, stalls, dout);
        check("inv_miss_stalls", stalls, 32'd6);
        check("inv_miss_no_wb", n_wr - wr0, 32'd0);
        check("inv_miss_dout", dout, 32'h00C0_00A1);

        check("edit_load_clash", n_clash, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cache_ctrl.md
# cache_ctrl

Miss-handling controller sitting between the pipeline memory stage and one `cache_line` store. It answers CPU reads and writes on hits with no wait states, stalls the pipeline on a miss, writes back a dirty victim line to main memory word by word, and refills the line. The store's `load`/`edit`/`invalid` strobes are driven only by this block. Write policy is write-back and write-allocate.

## Interface
Parameters (shared package values):
- `ADDR_BITS`, 32, address width
- `WORD_BITS`, 32, data word width
- `TAG_BITS`, 22, tag width
- `LINE_WORDS`, 4, words per line (`LINE_WORDS_WIDTH` = 2)
- `WORD_BYTES_WIDTH`, 2, byte offset bits

Ports:
- Clock and reset: one clock; reset is asynchronous and active-high.
- `clk` in 1: clock.
- `rst` in 1: asynchronous, active-high reset.
- `cpu_req` in 1: access request; must be held with `cpu_addr`, `cpu_we` and `cpu_din` stable while `cpu_stall`=1.
- `cpu_we` in 1: 1 = store, 0 = load.
- `cpu_addr` in 32: word address; bits [1:0] are ignored.
- `cpu_din` in 32: store data.
- `cpu_dout` out 32: load data; valid when `cpu_req & ~cpu_we & ~cpu_stall`.
- `cpu_stall` out 1: pipeline stall.
- `inv_req` in 1: invalidate the line selected by `cpu_addr`. Dirty data is discarded.
- `ln_addr` out 32: address to the line store.
- `ln_load`, `ln_edit`, `ln_invalid` out 1 each: line-store strobes.
- `ln_din` out 32: write data to the line store.
- `ln_hit`, `ln_valid`, `ln_dirty` in 1 each: line-store status.
- `ln_dout` in 32: line-store read data.
- `ln_tag` in 22: line-store tag.
- `mem_cs` out 1: memory transaction active.
- `mem_we` out 1: memory write enable.
- `mem_addr` out 32: memory word address.
- `mem_dout` out 32: data to memory.
- `mem_din` in 32: data from memory.
- `mem_ack` in 1: one-cycle pulse; the current word has completed.

## Operation
- States: IDLE, WB, FILL, DONE. The 2-bit `word_cnt` and the 22-bit `victim_tag` are registers.
- **IDLE**
  - `ln_addr` = `cpu_addr`.
  - Hit, load: `cpu_dout` = `ln_dout`, `cpu_stall`=0.
  - Hit, store: `ln_edit`=1, `ln_din` = `cpu_din`, `cpu_stall`=0.
  - Miss (`cpu_req & ~ln_hit`): `cpu_stall`=1 and `word_cnt` is cleared.
    - If `ln_valid & ln_dirty`: latch `victim_tag` = `ln_tag`, go to WB.
    - Otherwise go to FILL.
  - `inv_req & ~cpu_req`: `ln_invalid`=1 for one cycle; stay in IDLE. `cpu_req` has priority over `inv_req`.
- **WB**
  - `mem_cs`=1, `mem_we`=1.
  - `ln_addr` = `mem_addr` = {`victim_tag`, index, `word_cnt`, 2'b00}.
  - `mem_dout` = `ln_dout`.
  - On `mem_ack`: `word_cnt`++. When `word_cnt`==3, clear `word_cnt` and go to FILL.
- **FILL**
  - `mem_cs`=1, `mem_we`=0.
  - `mem_addr` = `ln_addr` = {`cpu_addr` tag, index, `word_cnt`, 2'b00}.
  - On `mem_ack`: `ln_load`=1 and `ln_din` = `mem_din`, then `word_cnt`++. When `word_cnt`==3, go to DONE.
  - `ln_hit` is ignored in this state; it rises after the first load.
- **DONE**
  - `cpu_stall`=1, then go to IDLE.
  - IDLE re-evaluates the request, which now hits. Stores merge into the line at that point via `ln_edit`.
- `cpu_stall` = (state≠IDLE) | (IDLE & `cpu_req` & ~`ln_hit`).
- In IDLE with no request, all strobes and `mem_cs` are 0.
- An `ln_edit` and an `ln_load` never occur in the same cycle.

## Timing
- Reset: state=IDLE, `word_cnt`=0, `victim_tag`=0.
  - Every strobe is 0, and `mem_cs`, `mem_we` and `cpu_stall` are 0 (no request present).
  - `mem_addr`, `mem_dout`, `ln_din` and `cpu_dout` are 0.
- Reset mid-miss: return to IDLE at once. `mem_cs` drops asynchronously and the memory transaction is abandoned. A partially filled line stays valid with mixed data; the CPU reissues the access after reset.
- Hit: zero wait states; the store is written at the edge that ends the cycle.
- Clean miss, `mem_ack` every cycle: 6 stalled cycles (1 IDLE, 4 FILL, 1 DONE); the access completes in cycle 7.
- Dirty miss, `mem_ack` every cycle: 10 stalled cycles.
- Slow memory: each `mem_ack` delay of k cycles adds k stalled cycles per word.
- `mem_ack` outside WB/FILL is ignored.
- `mem_addr` is stable from the rise of `mem_cs` until `mem_ack` for each word.
- `word_cnt` wraps 3→0 only on the final ack of a phase.

## Structure
- Address field widths, the state encoding (localparam, 2 bits) and the line geometry constants belong in the shared define header.
- The block is a single FSM module with no sub-module; `cache_line` is instantiated next to it at the top level.

## Test plan
- Read miss, clean, line invalid, `cpu_addr`=0x0000_0104, memory returns 0xA0..0xA3: 4 FILL acks at addresses 0x100, 0x104, 0x108, 0x10C; stall for 6 cycles; `cpu_dout`=0xA1.
- Store hit to 0x104 with data 0xDEAD_BEEF: `ln_edit` pulses once with no stall; a following load of 0x104 returns 0xDEADBEEF.
- Dirty miss on 0x0040_0104 (same index, other tag): 4 `mem_we` writes to 0x100..0x10C, including 0xDEADBEEF at 0x104, then 4 fills from 0x0040_0100; stall for 10 cycles.
- `mem_ack` delayed 3 cycles per word on a clean miss: stall for 18 cycles; `mem_addr` is held during each wait.
- `rst` asserted in the second FILL word: `mem_cs` and `cpu_stall` fall the same cycle, state is IDLE, and the next reissued access misses or hits per the line state.
- `inv_req` on a dirty line with `cpu_req`=0: `ln_invalid` pulses once and there is no memory traffic; the next read to that address misses cleanly (no WB).
